// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and default timing for the actuated phase
//               scheduler (phase codes, scheduler states, base durations).
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Signal phase codes; the index matches the bit position in call vectors.
  typedef enum logic [1:0] {
    NS_GREEN = 2'd0,
    EW_LEFT  = 2'd1,
    EW_GREEN = 2'd2,
    NS_LEFT  = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SELECT    = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    PRE_ISSUE = 3'd4,
    PRE_HOLD  = 3'd5
  } sched_state_t;

  // Default durations in sequencer ticks.
  localparam int GREEN_TIME  = 40;
  localparam int YELLOW_TIME = 4;
  localparam int LEFT_TIME   = 20;
  localparam int EXT_TIME    = 10;
  localparam int MAX_TIME    = 60;

  // Odd phase codes are the protected left-turn phases.
  function automatic logic is_left(input logic [1:0] p);
    return p[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_call_latch.sv
`default_nettype none
// ============================================================================
// Module      : traffic_call_latch
// Description : Latches detector calls per phase and picks the next pending
//               phase round-robin, starting just after the last served phase.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_call_latch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] call,
  input  logic [3:0] clr,
  input  logic [1:0] last_phase,
  output logic [3:0] pending,
  output logic [1:0] pick,
  output logic       any
);

  // Set on any call, clear on service; clear wins so a held call re-pends
  // one cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 4'b0000;
    end else begin
      pending <= (pending | call) & ~clr;
    end
  end

  // Walk offsets from farthest to nearest so the nearest pending phase after
  // last_phase is the one left standing; offset 4 wraps onto last_phase.
  always_comb begin
    logic [1:0] idx;
    idx  = 2'd0;
    pick = 2'd0;
    any  = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_phase + 2'(k);
      if (pending[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_sched.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_sched
// Description : Actuated phase scheduler. Selects the next called phase,
//               hands it to the sequencer over valid/ready, waits for done,
//               and handles emergency preemption and a done watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_sched #(
  parameter int GREEN_TIME  = traffic_pkg::GREEN_TIME,
  parameter int LEFT_TIME   = traffic_pkg::LEFT_TIME,
  parameter int EXT_TIME    = traffic_pkg::EXT_TIME,
  parameter int MAX_TIME    = traffic_pkg::MAX_TIME,
  parameter int TW          = 8,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    call,
  input  logic          preempt,
  input  logic [1:0]    preempt_phase,
  input  logic          seq_ready,
  input  logic          seq_done,
  output logic          phase_valid,
  output logic [1:0]    phase_id,
  output logic [TW-1:0] phase_time,
  output logic          seq_abort,
  output logic [3:0]    call_pending,
  output logic          preempt_active,
  output logic          fault
);

  import traffic_pkg::*;

  localparam int         WW         = $clog2(WDOG_CYCLES);
  localparam logic [1:0] REST_PHASE = NS_GREEN;

  sched_state_t  state, state_n;
  logic [1:0]    last_phase;
  logic [WW-1:0] wdog_cnt;
  logic [3:0]    clr;
  logic [1:0]    pick;
  logic          any;
  logic [1:0]    sel_phase;
  logic [TW-1:0] sel_time;
  int            base_time;
  int            sum_time;
  logic          accept;
  logic          load_sel, load_pre, take_last, abort_n, fault_set, wdog_run;

  assign phase_valid    = (state == ISSUE) || (state == PRE_ISSUE);
  assign preempt_active = (state == PRE_ISSUE) || (state == PRE_HOLD);
  assign accept         = phase_valid & seq_ready;

  // Only a normal issue that is actually taken (not displaced by preempt)
  // services its call.
  assign clr = (state == ISSUE && accept && !preempt) ? (4'b0001 << phase_id) : 4'b0000;

  traffic_call_latch u_latch (
    .clk        (clk),
    .rst_n      (rst_n),
    .call       (call),
    .clr        (clr),
    .last_phase (last_phase),
    .pending    (call_pending),
    .pick       (pick),
    .any        (any)
  );

  // Duration of the picked phase: base, plus extension if its detector is
  // still occupied, saturated; 32-bit arithmetic keeps the sum from wrapping.
  always_comb begin
    sel_phase = any ? pick : REST_PHASE;
    base_time = is_left(sel_phase) ? LEFT_TIME : GREEN_TIME;
    sum_time  = base_time + (call[sel_phase] ? EXT_TIME : 0);
    sel_time  = (sum_time > MAX_TIME) ? TW'(MAX_TIME) : TW'(sum_time);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and control strobes; preempt overrides every normal transition.
  always_comb begin
    state_n   = state;
    take_last = 1'b0;
    abort_n   = 1'b0;
    fault_set = 1'b0;
    wdog_run  = 1'b0;
    case (state)
      IDLE:   state_n = preempt ? PRE_ISSUE : SELECT;
      SELECT: state_n = preempt ? PRE_ISSUE : ISSUE;
      ISSUE: begin
        if (preempt) begin
          state_n = PRE_ISSUE;
        end else if (accept) begin
          state_n   = WAIT_DONE;
          take_last = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (preempt) begin
          state_n = PRE_ISSUE;
          abort_n = 1'b1;
        end else if (seq_done) begin
          state_n = SELECT;
        end else if (wdog_cnt == WW'(WDOG_CYCLES - 1)) begin
          state_n   = SELECT;
          fault_set = 1'b1;
          abort_n   = 1'b1;
        end else begin
          wdog_run = 1'b1;
        end
      end
      PRE_ISSUE: begin
        if (accept) state_n = PRE_HOLD;
      end
      PRE_HOLD: begin
        if (!preempt) begin
          state_n   = SELECT;
          take_last = 1'b1;
          abort_n   = !seq_done;
        end else if (seq_done) begin
          state_n = PRE_ISSUE;
        end
      end
      default: state_n = IDLE;
    endcase
    load_sel = (state == SELECT) && (state_n == ISSUE);
    load_pre = (state_n == PRE_ISSUE) && (state != PRE_ISSUE);
  end

  // Issue registers, round-robin pointer, watchdog, abort pulse and fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_id   <= 2'd0;
      phase_time <= '0;
      last_phase <= 2'd3;
      wdog_cnt   <= '0;
      seq_abort  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      if (load_sel) begin
        phase_id   <= sel_phase;
        phase_time <= sel_time;
      end else if (load_pre) begin
        phase_id   <= preempt_phase;
        phase_time <= TW'(MAX_TIME);
      end
      if (take_last) last_phase <= phase_id;
      wdog_cnt  <= wdog_run ? wdog_cnt + 1'b1 : '0;
      seq_abort <= abort_n;
      if (fault_set) fault <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_sched
// Description : Directed scoreboard bench for traffic_phase_sched. A second
//               instance with LEFT_TIME=55 shares all inputs to observe
//               saturation of phase_time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] call;
  logic       preempt;
  logic [1:0] preempt_phase;
  logic       seq_ready;
  logic       seq_done;

  logic       phase_valid, seq_abort, preempt_active, fault;
  logic [1:0] phase_id;
  logic [7:0] phase_time;
  logic [3:0] call_pending;

  logic       phase_valid2, seq_abort2, preempt_active2, fault2;
  logic [1:0] phase_id2;
  logic [7:0] phase_time2;
  logic [3:0] call_pending2;

  typedef struct {
    logic [1:0] id;
    logic [7:0] t;
    logic [7:0] t2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   errs    = 0;

  traffic_phase_sched dut (
    .clk(clk), .rst_n(rst_n), .call(call), .preempt(preempt),
    .preempt_phase(preempt_phase), .seq_ready(seq_ready), .seq_done(seq_done),
    .phase_valid(phase_valid), .phase_id(phase_id), .phase_time(phase_time),
    .seq_abort(seq_abort), .call_pending(call_pending),
    .preempt_active(preempt_active), .fault(fault)
  );

  traffic_phase_sched #(.LEFT_TIME(55)) dut_sat (
    .clk(clk), .rst_n(rst_n), .call(call), .preempt(preempt),
    .preempt_phase(preempt_phase), .seq_ready(seq_ready), .seq_done(seq_done),
    .phase_valid(phase_valid2), .phase_id(phase_id2), .phase_time(phase_time2),
    .seq_abort(seq_abort2), .call_pending(call_pending2),
    .preempt_active(preempt_active2), .fault(fault2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_done();
    seq_done = 1'b1;
    cyc(1);
    seq_done = 1'b0;
  endtask

  // Returns just after the clock edge on which the handshake completed.
  task automatic wait_accept(input int maxc);
    int n;
    n = 0;
    @(negedge clk);
    while (!(phase_valid && seq_ready) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) chk("accept_timeout", 32'(n), 32'(maxc - 1));
    @(posedge clk);
    #1;
  endtask

  task automatic rnd();
    wait_accept(50);
    cyc(5);
    pulse_done();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid",   phase_valid,    0);
    chk("rst_id",      phase_id,       0);
    chk("rst_time",    phase_time,     0);
    chk("rst_abort",   seq_abort,      0);
    chk("rst_pending", call_pending,   0);
    chk("rst_preact",  preempt_active, 0);
    chk("rst_fault",   fault,          0);
  endtask

  // Scoreboard: every accepted issue is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && phase_valid && seq_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(phase_id), 32'hFFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("issue_id",       phase_id,    mon_e.id);
        chk("issue_time",     phase_time,  mon_e.t);
        chk("issue_time_sat", phase_time2, mon_e.t2);
      end
    end
  end

  initial begin
    rst_n = 1'b0; call = 4'b0; preempt = 1'b0; preempt_phase = 2'd0;
    seq_ready = 1'b0; seq_done = 1'b0;
    cyc(2);
    chk_reset_outputs();

    // Rest on NS_GREEN with no calls.
    rst_n = 1'b1;
    seq_ready = 1'b1;
    repeat (3) sb.push_back('{2'd0, 8'd40, 8'd40});
    rnd();
    chk("rest_pending0", call_pending, 0);
    rnd();
    wait_accept(50);
    chk("rest_pending1", call_pending, 0);

    // Pulsed calls on both left phases.
    call = 4'b1010;
    cyc(1);
    call = 4'b0000;
    chk("pulse_latch", call_pending, 4'b1010);
    sb.push_back('{2'd1, 8'd20, 8'd55});
    sb.push_back('{2'd3, 8'd20, 8'd55});
    sb.push_back('{2'd0, 8'd40, 8'd40});
    cyc(4);
    pulse_done();
    wait_accept(50);
    chk("clr_after_p1", call_pending, 4'b1000);
    cyc(5);
    pulse_done();
    wait_accept(50);
    chk("clr_after_p3", call_pending, 4'b0000);
    pulse_done();
    wait_accept(50);

    // Held call extends the green and re-pends after acceptance.
    call = 4'b0100;
    sb.push_back('{2'd2, 8'd50, 8'd50});
    pulse_done();
    wait_accept(50);
    chk("held_clear_wins", call_pending, 4'b0000);
    cyc(1);
    chk("held_repend", call_pending, 4'b0100);
    call = 4'b1000;
    sb.push_back('{2'd3, 8'd30, 8'd60});
    pulse_done();
    wait_accept(50);
    call = 4'b0000;
    sb.push_back('{2'd2, 8'd40, 8'd40});
    pulse_done();
    wait_accept(50);

    // Preempt during WAIT_DONE of phase 1.
    call = 4'b0010;
    cyc(1);
    call = 4'b0000;
    sb.push_back('{2'd1, 8'd20, 8'd55});
    pulse_done();
    wait_accept(50);
    sb.push_back('{2'd2, 8'd60, 8'd60});
    preempt = 1'b1;
    preempt_phase = 2'd2;
    cyc(1);
    chk("pre_abort",  seq_abort,      1);
    chk("pre_active", preempt_active, 1);
    chk("pre_valid",  phase_valid,    1);
    chk("pre_id",     phase_id,       2);
    chk("pre_time",   phase_time,     60);
    cyc(1);
    chk("hold_abort",  seq_abort,      0);
    chk("hold_valid",  phase_valid,    0);
    chk("hold_active", preempt_active, 1);
    call = 4'b1001;
    cyc(1);
    call = 4'b0000;
    sb.push_back('{2'd2, 8'd60, 8'd60});
    pulse_done();
    chk("reissue_valid", phase_valid, 1);
    wait_accept(50);
    chk("pre_keeps_pending", call_pending, 4'b1001);
    preempt = 1'b0;
    sb.push_back('{2'd3, 8'd20, 8'd55});
    sb.push_back('{2'd0, 8'd40, 8'd40});
    cyc(1);
    chk("release_abort",  seq_abort,      1);
    chk("release_active", preempt_active, 0);
    rnd();
    wait_accept(50);

    // Watchdog: withhold done; sequencer busy when the next phase appears.
    cyc(4095);
    chk("wdog_nofault_early", fault,     0);
    chk("wdog_noabort_early", seq_abort, 0);
    seq_ready = 1'b0;
    sb.push_back('{2'd0, 8'd40, 8'd40});
    cyc(1);
    chk("wdog_fault", fault,     1);
    chk("wdog_abort", seq_abort, 1);
    cyc(1);
    chk("wdog_abort_pulse", seq_abort,   0);
    chk("wdog_reissue",     phase_valid, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("stall_valid", phase_valid, 1);
      chk("stall_id",    phase_id,    0);
      chk("stall_time",  phase_time,  40);
    end
    seq_ready = 1'b1;
    wait_accept(50);
    chk("fault_sticky", fault, 1);

    // Asynchronous reset in WAIT_DONE with the fault set.
    rst_n = 1'b0;
    #2;
    chk_reset_outputs();
    cyc(1);
    rst_n = 1'b1;
    sb.push_back('{2'd0, 8'd40, 8'd40});
    wait_accept(50);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
`default_nettype wire
